// File: rtl/afe_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : afe_sample_tx
// Purpose  : Transmit side of the AFE sample word interface. Samples arrive on
//            a valid/ready handshake and are packed into 32-bit words. Each
//            word carries its channel ID. Every word is driven as a
//            level-held valid pulse followed by a guaranteed low gap, so that
//            slow-domain 3-flop synchronizers with rising-edge detectors see
//            each word exactly once.
// Ports    : clk_i, rst_i          clock, synchronous active-high reset
//            cfg_sel_i/cfg_wr_i    register access select / write strobe
//            cfg_addr_i            register address ([2:0] decoded)
//            cfg_wdata_i           write data
//            cfg_rdata_o           combinational read data (0 when idle)
//            sample_valid_i        sample offered
//            sample_ready_o        sample accepted when valid & ready
//            sample_ch_i           sample channel
//            sample_data_i         signed sample
//            afe_data_vld_o        word valid level
//            afe_data_o            packed word
// Options  : AFE_TX_SEQ_EN - adds a 4-bit per-word sequence number at word
//            bits [CH_ID_LSB-1:CH_ID_LSB-4], readable at SENT_CNT[19:16].
// Revision : 1.0 - initial release
// ============================================================================
module afe_sample_tx #(
  parameter int W_CFG_ADDR  = 10,
  parameter int W_AFE_DATA  = 16,
  parameter int NUM_CH      = 8,
  parameter int CH_ID_LSB   = 28,
  parameter int CH_ID_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_sel_i,
  input  logic                   cfg_wr_i,
  input  logic [W_CFG_ADDR-1:0]  cfg_addr_i,
  input  logic [31:0]            cfg_wdata_i,
  output logic [31:0]            cfg_rdata_o,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  input  logic [CH_ID_WIDTH-1:0] sample_ch_i,
  input  logic [W_AFE_DATA-1:0]  sample_data_i,
  output logic                   afe_data_vld_o,
  output logic [31:0]            afe_data_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] C_ADDR_CTRL     = 3'd0;
  localparam logic [2:0] C_ADDR_TIMING   = 3'd1;
  localparam logic [2:0] C_ADDR_CH_MASK  = 3'd2;
  localparam logic [2:0] C_ADDR_STATUS   = 3'd3;
  localparam logic [2:0] C_ADDR_DROP_CNT = 3'd4;
  localparam logic [2:0] C_ADDR_SENT_CNT = 3'd5;

  // Shortest hold/gap the downstream 3-flop synchronizer can resolve.
  localparam logic [7:0] C_MIN_CYC = 8'd3;

  // One extra bit so NUM_CH == 2**CH_ID_WIDTH still fits.
  localparam logic [CH_ID_WIDTH:0] C_NUM_CH = (CH_ID_WIDTH+1)'(NUM_CH);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_en;
  logic [7:0]        r_hold_cyc;
  logic [7:0]        r_gap_cyc;
  logic [NUM_CH-1:0] r_mask;
  logic [7:0]        r_drop_cnt;
  logic [15:0]       r_sent_cnt;
  logic              r_vld;
  logic [31:0]       r_data;
`ifdef AFE_TX_SEQ_EN
  logic [3:0]        r_seq;
`endif

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              w_cfg_wr;
  logic              w_cfg_rd;
  logic [2:0]        w_addr;
  logic              w_ready;
  logic              w_handshake;
  logic [NUM_CH-1:0] w_mask_shift;
  logic              w_ch_ok;
  logic              w_accept;
  logic              w_drop;
  logic              w_drop_rd;
  logic [7:0]        w_hold_load;
  logic [7:0]        w_gap_load;
  logic [31:0]       w_word;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_cfg_wr = cfg_sel_i & cfg_wr_i;
  assign w_cfg_rd = cfg_sel_i & ~cfg_wr_i;
  assign w_addr   = cfg_addr_i[2:0];

  // Ready only while idle; disabling en mid-word never aborts the word.
  assign w_ready     = (r_state == ST_IDLE) & r_en;
  assign w_handshake = sample_valid_i & w_ready;

  // Shift instead of a bit-select so an out-of-range channel never indexes
  // past the mask; the range compare then qualifies the result.
  assign w_mask_shift = r_mask >> sample_ch_i;
  assign w_ch_ok      = ({1'b0, sample_ch_i} < C_NUM_CH) & w_mask_shift[0];
  assign w_accept     = w_handshake & w_ch_ok;
  assign w_drop       = w_handshake & ~w_ch_ok;
  assign w_drop_rd    = w_cfg_rd & (w_addr == C_ADDR_DROP_CNT);

  // Counters are loaded with (effective length - 1) and run down to 0.
  assign w_hold_load = ((r_hold_cyc < C_MIN_CYC) ? C_MIN_CYC : r_hold_cyc) - 8'd1;
  assign w_gap_load  = ((r_gap_cyc  < C_MIN_CYC) ? C_MIN_CYC : r_gap_cyc)  - 8'd1;

  // Upper address bits, unused write-data bits and upper mask-shift bits are
  // intentionally ignored.
  assign w_unused = ^{cfg_addr_i, cfg_wdata_i, w_mask_shift};

  always_comb begin
    w_word = '0;
    w_word[CH_ID_LSB +: CH_ID_WIDTH] = sample_ch_i;
    w_word[W_AFE_DATA-1:0]           = sample_data_i;
`ifdef AFE_TX_SEQ_EN
    w_word[CH_ID_LSB-4 +: 4]         = r_seq;
`endif
  end

  always_comb begin
    w_rdata = '0;
    if (w_cfg_rd) begin
      case (w_addr)
        C_ADDR_CTRL: w_rdata[0] = r_en;
        C_ADDR_TIMING: begin
          w_rdata[7:0]   = r_hold_cyc;
          w_rdata[23:16] = r_gap_cyc;
        end
        C_ADDR_CH_MASK:  w_rdata[NUM_CH-1:0] = r_mask;
        C_ADDR_STATUS:   w_rdata[0]          = (r_state != ST_IDLE);
        C_ADDR_DROP_CNT: w_rdata[7:0]        = r_drop_cnt;
        C_ADDR_SENT_CNT: begin
          w_rdata[15:0] = r_sent_cnt;
`ifdef AFE_TX_SEQ_EN
          w_rdata[19:16] = r_seq;
`endif
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign cfg_rdata_o    = w_rdata;
  assign sample_ready_o = w_ready;
  assign afe_data_vld_o = r_vld;
  assign afe_data_o     = r_data;

  // --------------------------------------------------------------------------
  // Registers, counters and word FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_en       <= 1'b0;
      r_hold_cyc <= 8'd4;
      r_gap_cyc  <= 8'd4;
      r_mask     <= '0;
      r_drop_cnt <= 8'd0;
      r_sent_cnt <= 16'd0;
      r_vld      <= 1'b0;
      r_data     <= 32'd0;
`ifdef AFE_TX_SEQ_EN
      r_seq      <= 4'd0;
`endif
    end else begin
      // Register writes; RO and unmapped addresses fall through.
      if (w_cfg_wr) begin
        case (w_addr)
          C_ADDR_CTRL: r_en <= cfg_wdata_i[0];
          C_ADDR_TIMING: begin
            r_hold_cyc <= cfg_wdata_i[7:0];
            r_gap_cyc  <= cfg_wdata_i[23:16];
          end
          C_ADDR_CH_MASK: r_mask <= cfg_wdata_i[NUM_CH-1:0];
          default: ;
        endcase
      end

      // Drop counter: a drop coincident with a read leaves 1, so the drop
      // that arrived during the read is never lost.
      if (w_drop) begin
        if (w_drop_rd) begin
          r_drop_cnt <= 8'd1;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (w_drop_rd) begin
        r_drop_cnt <= 8'd0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data     <= w_word;
            r_vld      <= 1'b1;
            r_cnt      <= w_hold_load;
            r_state    <= ST_HOLD;
            r_sent_cnt <= r_sent_cnt + 16'd1;
`ifdef AFE_TX_SEQ_EN
            r_seq      <= r_seq + 4'd1;
`endif
          end
        end
        ST_HOLD: begin
          if (r_cnt == 8'd0) begin
            r_vld   <= 1'b0;
            r_cnt   <= w_gap_load;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_afe_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_afe_sample_tx
// Purpose  : Self-checking bench for afe_sample_tx. A register/scoreboard
//            model predicts read data, packed words and pulse/gap lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afe_sample_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_sel_i = 1'b0;
  logic        cfg_wr_i = 1'b0;
  logic [9:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [3:0]  sample_ch_i = '0;
  logic [15:0] sample_data_i = '0;
  logic        afe_data_vld_o;
  logic [31:0] afe_data_o;

  afe_sample_tx dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_wr_i       (cfg_wr_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_wdata_i    (cfg_wdata_i),
    .cfg_rdata_o    (cfg_rdata_o),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sample_ch_i    (sample_ch_i),
    .sample_data_i  (sample_data_i),
    .afe_data_vld_o (afe_data_vld_o),
    .afe_data_o     (afe_data_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the programmer-visible state
  logic        m_en;
  logic [7:0]  m_hold;
  logic [7:0]  m_gap;
  logic [7:0]  m_mask;
  logic [7:0]  m_drop;
  logic [15:0] m_sent;
  logic [3:0]  m_seq;

  task automatic model_reset();
    m_en = 1'b0; m_hold = 8'd4; m_gap = 8'd4; m_mask = 8'd0;
    m_drop = 8'd0; m_sent = 16'd0; m_seq = 4'd0;
  endtask

  function automatic int eff(input logic [7:0] v);
    return (v < 8'd3) ? 3 : int'(v);
  endfunction

  function automatic bit ch_enabled(input logic [3:0] ch);
    return (ch < 4'd8) && (((m_mask >> ch) & 8'h01) != 8'h00);
  endfunction

  function automatic logic [31:0] exp_word(input logic [3:0] ch, input logic [15:0] d);
    logic [31:0] w;
    w = 32'(d) | (32'(ch) << 28);
`ifdef AFE_TX_SEQ_EN
    w = w | (32'(m_seq) << 24);
`endif
    return w;
  endfunction

  // Only called while the model is idle, so STATUS.busy is expected 0.
  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {31'd0, m_en};
      3'd1: return {8'd0, m_gap, 8'd0, m_hold};
      3'd2: return {24'd0, m_mask};
      3'd4: return {24'd0, m_drop};
`ifdef AFE_TX_SEQ_EN
      3'd5: return {12'd0, m_seq, m_sent};
`else
      3'd5: return {16'd0, m_sent};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_sel_i = 1'b1; cfg_wr_i = 1'b1; cfg_addr_i = 10'(a); cfg_wdata_i = d;
    tick();
    cfg_sel_i = 1'b0; cfg_wr_i = 1'b0;
    case (a)
      3'd0: m_en = d[0];
      3'd1: begin m_hold = d[7:0]; m_gap = d[23:16]; end
      3'd2: m_mask = d[7:0];
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    logic [31:0] e;
    e = model_read(a);
    cfg_sel_i = 1'b1; cfg_wr_i = 1'b0; cfg_addr_i = 10'(a);
    #1;
    chk(tag, cfg_rdata_o, e);
    tick();
    cfg_sel_i = 1'b0;
    if (a == 3'd4) m_drop = 8'd0;
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (sample_ready_o !== 1'b1 && g < 600) begin tick(); g++; end
    chk(tag, 32'(g < 600), 32'd1);
  endtask

  // Offer one sample, then verify the emitted word (value, hold and gap
  // lengths) or the drop, against the model.
  task automatic send(input logic [3:0] ch, input logic [15:0] d);
    int n;
    bit emit;
    logic [31:0] ew;
    emit = ch_enabled(ch);
    ew = exp_word(ch, d);
    sample_valid_i = 1'b1; sample_ch_i = ch; sample_data_i = d;
    #1;
    wait_ready("send_ready_timeout");
    tick();
    sample_valid_i = 1'b0;
    if (emit) begin
      m_sent++; m_seq++;
      chk("vld_rise", 32'(afe_data_vld_o), 32'd1);
      chk("word", afe_data_o, ew);
      n = 0;
      while (afe_data_vld_o === 1'b1 && n < 600) begin n++; tick(); end
      chk("hold_len", n, eff(m_hold));
      chk("word_stable", afe_data_o, ew);
      n = 0;
      while (sample_ready_o !== 1'b1 && afe_data_vld_o === 1'b0 && n < 600) begin n++; tick(); end
      chk("gap_len", n, eff(m_gap));
    end else begin
      m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
      chk("drop_no_vld", 32'(afe_data_vld_o), 32'd0);
      chk("drop_stay_idle", 32'(sample_ready_o), 32'd1);
    end
  endtask

  initial begin
    int n;
    int t_prev;
    logic [31:0] ew;
    model_reset();

    // ---------------- reset state ----------------
    rst_i = 1'b1;
    tick(); tick(); tick();
    chk("rst_vld", 32'(afe_data_vld_o), 32'd0);
    chk("rst_data", afe_data_o, 32'd0);
    chk("rst_ready", 32'(sample_ready_o), 32'd0);
    rst_i = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), "rst_reg");
    chk("rdata_idle", cfg_rdata_o, 32'd0);

    // ---------------- single word ----------------
    wr(3'd0, 32'd1);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h0004_0004);
    rd(3'd0, "ctrl_rb");
    rd(3'd2, "mask_rb");
    wr(3'd3, 32'hFFFF_FFFF);        // RO: ignored
    wr(3'd5, 32'hFFFF_FFFF);        // RO: ignored
    send(4'd0, 16'h8001);
    rd(3'd5, "sent_single");
    rd(3'd3, "status_idle");

    // ---------------- back-to-back ----------------
    wr(3'd2, 32'hFF);
    sample_valid_i = 1'b1; sample_ch_i = 4'd3; sample_data_i = 16'h0123;
    #1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready("b2b_ready_timeout");
      if (k > 0) chk("b2b_period", cyc - t_prev, eff(m_hold) + eff(m_gap) + 1);
      t_prev = cyc;
      ew = exp_word(4'd3, 16'h0123);
      tick();
      m_sent++; m_seq++;
      chk("b2b_vld", 32'(afe_data_vld_o), 32'd1);
      chk("b2b_word", afe_data_o, ew);
    end
    sample_valid_i = 1'b0;
    wait_ready("b2b_drain");
    rd(3'd5, "sent_b2b");

    // ---------------- drops ----------------
    wr(3'd2, 32'h0F);
    send(4'd5, 16'h1111);
    send(4'd9, 16'h2222);
    rd(3'd4, "drop_two");
    rd(3'd4, "drop_cleared");
    send(4'd5, 16'h3333);
    // drop coincident with a DROP_CNT read
    sample_valid_i = 1'b1; sample_ch_i = 4'd9; sample_data_i = 16'h4444;
    cfg_sel_i = 1'b1; cfg_wr_i = 1'b0; cfg_addr_i = 10'd4;
    #1;
    chk("collide_rdata", cfg_rdata_o, model_read(3'd4));
    chk("collide_ready", 32'(sample_ready_o), 32'd1);
    tick();
    sample_valid_i = 1'b0; cfg_sel_i = 1'b0;
    m_drop = 8'd1;
    rd(3'd4, "drop_collide");
    rd(3'd4, "drop_after_collide");

    // ---------------- clamp ----------------
    wr(3'd1, 32'h0001_0000);
    send(4'd1, 16'hBEEF);

    // ---------------- randomized ----------------
    for (int i = 0; i < 24; i++) begin
      wr(3'd1, {8'd0, 8'($urandom_range(0, 6)), 8'd0, 8'($urandom_range(0, 6))});
      wr(3'd2, 32'(8'($urandom)));
      send(4'($urandom_range(0, 15)), 16'($urandom));
      if (i % 6 == 5) begin
        rd(3'd4, "rand_drop");
        rd(3'd5, "rand_sent");
      end
    end

    // ---------------- disable mid-word ----------------
    wr(3'd1, 32'h0004_0004);
    wr(3'd2, 32'hFF);
    ew = exp_word(4'd2, 16'h5A5A);
    sample_valid_i = 1'b1; sample_ch_i = 4'd2; sample_data_i = 16'h5A5A;
    #1;
    wait_ready("dis_ready_timeout");
    tick();
    m_sent++; m_seq++;
    chk("dis_vld", 32'(afe_data_vld_o), 32'd1);
    cfg_sel_i = 1'b1; cfg_wr_i = 1'b1; cfg_addr_i = 10'd0; cfg_wdata_i = 32'd0;
    m_en = 1'b0;
    n = 0;
    while (afe_data_vld_o === 1'b1 && n < 600) begin
      n++; tick(); cfg_sel_i = 1'b0; cfg_wr_i = 1'b0;
    end
    chk("dis_hold_len", n, eff(m_hold));
    chk("dis_word", afe_data_o, ew);
    for (int i = 0; i < 10; i++) begin
      chk("dis_ready_low", 32'(sample_ready_o), 32'd0);
      chk("dis_no_vld", 32'(afe_data_vld_o), 32'd0);
      tick();
    end
    sample_valid_i = 1'b0;
    rd(3'd3, "dis_status");
    rd(3'd0, "dis_ctrl");
    rd(3'd5, "dis_sent");

    // ---------------- reset during HOLD ----------------
    wr(3'd0, 32'd1);
    wr(3'd1, 32'h0007_0009);
    sample_valid_i = 1'b1; sample_ch_i = 4'd6; sample_data_i = 16'h7777;
    #1;
    wait_ready("rst_ready_timeout");
    tick();
    sample_valid_i = 1'b0;
    chk("rst_hold_vld", 32'(afe_data_vld_o), 32'd1);
    rst_i = 1'b1;
    tick();
    chk("rst_mid_vld", 32'(afe_data_vld_o), 32'd0);
    chk("rst_mid_data", afe_data_o, 32'd0);
    chk("rst_mid_ready", 32'(sample_ready_o), 32'd0);
    rst_i = 1'b0;
    model_reset();
    rd(3'd3, "rst_busy");
    rd(3'd1, "rst_timing");
    rd(3'd5, "rst_sent");
    rd(3'd0, "rst_ctrl");
    rd(3'd2, "rst_mask");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
